// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and word-slot helper for the I-cache block-fill path.
package icache_pkg;

  localparam int WORD_WIDTH     = 20;
  localparam int NUM_WORDS      = 16;
  localparam int OFFSET_WIDTH   = $clog2(NUM_WORDS);
  localparam int MEM_DATA_WIDTH = WORD_WIDTH * NUM_WORDS;
  localparam int ADDR_WIDTH     = 16;
  localparam int BLK_ADDR_WIDTH = ADDR_WIDTH - OFFSET_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } fill_state_e;

  // LSB position of word slot k inside the assembled block
  function automatic int slot_lsb(input int k);
    return k * WORD_WIDTH;
  endfunction

endpackage

// File: rtl/block_fill_responder_if.sv
// Request, backing-memory and block-output signals of the block-fill responder.
interface block_fill_responder_if;
  import icache_pkg::*;

  logic                      i_req_valid;
  logic                      o_req_ready;
  logic [BLK_ADDR_WIDTH-1:0] i_req_blk_addr;
  logic [OFFSET_WIDTH-1:0]   i_req_offset;

  logic                      o_rd_en;
  logic [ADDR_WIDTH-1:0]     o_rd_addr;
  logic [WORD_WIDTH-1:0]     i_rd_data;
  logic                      i_rd_valid;

  logic [WORD_WIDTH-1:0]     o_crit_word;
  logic                      o_crit_valid;
  logic [MEM_DATA_WIDTH-1:0] o_mem_data;
  logic [OFFSET_WIDTH-1:0]   o_block_offset_bits;
  logic                      o_valid;
  logic                      i_ready;

  modport master (
    input  i_req_valid, i_req_blk_addr, i_req_offset, i_rd_data, i_rd_valid, i_ready,
    output o_req_ready, o_rd_en, o_rd_addr, o_crit_word, o_crit_valid,
           o_mem_data, o_block_offset_bits, o_valid
  );

  modport slave (
    output i_req_valid, i_req_blk_addr, i_req_offset, i_rd_data, i_rd_valid, i_ready,
    input  o_req_ready, o_rd_en, o_rd_addr, o_crit_word, o_crit_valid,
           o_mem_data, o_block_offset_bits, o_valid
  );

endinterface

// File: rtl/block_word_writer.sv
// Registered block line; one word slot at a time is written through a one-hot enable.
module block_word_writer
  import icache_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [OFFSET_WIDTH-1:0]   i_idx,
  input  logic [WORD_WIDTH-1:0]     i_wdata,
  output logic [MEM_DATA_WIDTH-1:0] o_line
);

  logic [NUM_WORDS-1:0]      sel;
  logic [MEM_DATA_WIDTH-1:0] line_q, line_d;

  assign sel = i_we ? (NUM_WORDS'(1) << i_idx) : '0;

  always_comb begin
    line_d = line_q;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (sel[k]) line_d[slot_lsb(k) +: WORD_WIDTH] = i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) line_q <= '0;
    else       line_q <= line_d;
  end

  assign o_line = line_q;

endmodule

// File: rtl/block_fill_responder.sv
// Fetches a 16-word block critical-word-first, one outstanding read at a time,
// and presents the assembled block with its miss offset on a valid/ready output.
module block_fill_responder
  import icache_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_rst,
  block_fill_responder_if.master bus
);

  fill_state_e               state_q, state_d;
  logic [BLK_ADDR_WIDTH-1:0] blk_q, blk_d;
  logic [OFFSET_WIDTH-1:0]   off_q, off_d;
  logic [OFFSET_WIDTH-1:0]   idx_q, idx_d;
  logic [OFFSET_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]     crit_word_q, crit_word_d;
  logic                      crit_valid_q, crit_valid_d;
  logic                      wr_en;
  logic [MEM_DATA_WIDTH-1:0] mem_line;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      blk_q        <= '0;
      off_q        <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      crit_word_q  <= '0;
      crit_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      off_q        <= off_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      crit_word_q  <= crit_word_d;
      crit_valid_q <= crit_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    blk_d        = blk_q;
    off_d        = off_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    crit_word_d  = crit_word_q;
    crit_valid_d = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          blk_d   = bus.i_req_blk_addr;
          off_d   = bus.i_req_offset;
          idx_d   = bus.i_req_offset;
          cnt_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.i_rd_valid) begin
          wr_en = 1'b1;
          // The first return of a request is the missed word
          if (cnt_q == '0) begin
            crit_word_d  = bus.i_rd_data;
            crit_valid_d = 1'b1;
          end
          idx_d   = idx_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == OFFSET_WIDTH'(NUM_WORDS - 1)) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        if (bus.i_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  block_word_writer u_writer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (wr_en),
    .i_idx   (idx_q),
    .i_wdata (bus.i_rd_data),
    .o_line  (mem_line)
  );

  assign bus.o_req_ready         = (state_q == ST_IDLE);
  assign bus.o_rd_en             = (state_q == ST_ISSUE);
  assign bus.o_rd_addr           = {blk_q, idx_q};
  assign bus.o_crit_word         = crit_word_q;
  assign bus.o_crit_valid        = crit_valid_q;
  assign bus.o_mem_data          = mem_line;
  assign bus.o_block_offset_bits = off_q;
  assign bus.o_valid             = (state_q == ST_DONE);

endmodule
